// File: rtl/vend_controller_if.sv
// Coin, door and hopper signals of the vending transaction sequencer.
// The master modport is the environment side and the slave modport is the controller side.
interface vend_controller_if #(
    parameter int CW = 6
);
    logic          N;
    logic          D;
    logic          cancel;
    logic          open_ack;
    logic          chg_busy;
    logic          open;
    logic          chg_n;
    logic          chg_d;
    logic          coin_reject;
    logic [CW-1:0] credit;
    logic          busy;

    modport master (
        output N, D, cancel, open_ack, chg_busy,
        input  open, chg_n, chg_d, coin_reject, credit, busy
    );

    modport slave (
        input  N, D, cancel, open_ack, chg_busy,
        output open, chg_n, chg_d, coin_reject, credit, busy
    );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction sequencer: it collects coins, requests a dispense, and returns change.
// Defining VEND_DIME_CHANGE_EN returns change in dimes where possible; by default all change is paid in nickels.
module vend_controller #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 35,
    parameter int CW         = 6
) (
    input  logic              clk,
    input  logic              reset,
    vend_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    localparam logic [CW:0]   ZERO_W   = {(CW+1){1'b0}};
    localparam logic [CW:0]   NICKEL_W = (CW+1)'(32'd5);
    localparam logic [CW:0]   DIME_W   = (CW+1)'(32'd10);
    localparam logic [CW:0]   MAX_W    = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
    localparam logic [CW-1:0] FIVE_C   = CW'(32'd5);
    localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);

    state_t        state_r;
    logic [CW-1:0] credit_r;
    logic          open_r;
    logic          chg_n_r;
    logic          coin_reject_r;
    logic          busy_r;
    logic          pulse_prev_r;

    logic [CW:0]   coin_val_s;
    logic [CW:0]   sum_s;
    logic          coin_s;
    logic          fits_s;
    logic [CW-1:0] new_credit_s;
    logic [CW-1:0] remainder_s;

`ifdef VEND_DIME_CHANGE_EN
    localparam logic [CW-1:0] TEN_C = CW'(32'd10);
    logic chg_d_r;
    assign bus.chg_d = chg_d_r;
`else
    assign bus.chg_d = 1'b0;
`endif

    assign bus.open        = open_r;
    assign bus.chg_n       = chg_n_r;
    assign bus.coin_reject = coin_reject_r;
    assign bus.credit      = credit_r;
    assign bus.busy        = busy_r;

    // Coin arithmetic uses one extra bit so the overflow test cannot wrap.
    always_comb begin
        coin_val_s  = (bus.N ? NICKEL_W : ZERO_W) + (bus.D ? DIME_W : ZERO_W);
        sum_s       = {1'b0, credit_r} + coin_val_s;
        coin_s      = bus.N | bus.D;
        fits_s      = (sum_s <= MAX_W);
        remainder_s = credit_r - PRICE_C;
        if (coin_s && fits_s) begin
            new_credit_s = sum_s[CW-1:0];
        end else begin
            new_credit_s = credit_r;
        end
    end

    // Sequencer: state, credit and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= COLLECT;
            credit_r      <= ZERO_C;
            open_r        <= 1'b0;
            chg_n_r       <= 1'b0;
            coin_reject_r <= 1'b0;
            busy_r        <= 1'b0;
            pulse_prev_r  <= 1'b0;
`ifdef VEND_DIME_CHANGE_EN
            chg_d_r       <= 1'b0;
`endif
        end else begin
            chg_n_r       <= 1'b0;
            coin_reject_r <= 1'b0;
            pulse_prev_r  <= 1'b0;
`ifdef VEND_DIME_CHANGE_EN
            chg_d_r       <= 1'b0;
`endif
            case (state_r)
                COLLECT: begin
                    credit_r      <= new_credit_s;
                    coin_reject_r <= coin_s & ~fits_s;
                    // A refund takes priority over a dispense when cancel arrives together with the final coin.
                    if (bus.cancel && (new_credit_s != ZERO_C)) begin
                        state_r <= CHANGE;
                        busy_r  <= 1'b1;
                    end else if (new_credit_s >= PRICE_C) begin
                        state_r <= DISPENSE;
                        open_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= COLLECT;
                    end
                end
                DISPENSE: begin
                    coin_reject_r <= coin_s;
                    if (bus.open_ack) begin
                        credit_r <= remainder_s;
                        open_r   <= 1'b0;
                        if (remainder_s != ZERO_C) begin
                            state_r <= CHANGE;
                        end else begin
                            state_r <= COLLECT;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= DISPENSE;
                    end
                end
                CHANGE: begin
                    coin_reject_r <= coin_s;
                    if (credit_r == ZERO_C) begin
                        state_r <= COLLECT;
                        busy_r  <= 1'b0;
                    end else if (!bus.chg_busy && !pulse_prev_r) begin
                        pulse_prev_r <= 1'b1;
`ifdef VEND_DIME_CHANGE_EN
                        if (credit_r >= TEN_C) begin
                            chg_d_r  <= 1'b1;
                            credit_r <= credit_r - TEN_C;
                        end else
`endif
                        begin
                            chg_n_r  <= 1'b1;
                            credit_r <= credit_r - FIVE_C;
                        end
                    end else begin
                        state_r <= CHANGE;
                    end
                end
                default: begin
                    state_r  <= COLLECT;
                    credit_r <= ZERO_C;
                    open_r   <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: two configurations share the same stimulus, and each one is
// checked against its own cycle-level reference of the vending rules.
module tb_vend_controller;

    typedef struct {
        bit open;
        bit chg_n;
        bit chg_d;
        bit rej;
        bit busy;
        int credit;
    } obs_t;

    typedef struct {
        int credit;
        int phase;   // 0 collecting, 1 door open, 2 refunding
        bit prev;
    } mdl_t;

`ifdef VEND_DIME_CHANGE_EN
    localparam bit DIME = 1'b1;
`else
    localparam bit DIME = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vend_controller_if #(.CW(6)) bus_a ();
    vend_controller_if #(.CW(6)) bus_b ();

    vend_controller #(.PRICE(15), .MAX_CREDIT(35), .CW(6)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    vend_controller #(.PRICE(30), .MAX_CREDIT(30), .CW(6)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    obs_t qa[$];
    obs_t qb[$];
    mdl_t ma;
    mdl_t mb;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic void model_step(inout mdl_t m, output obs_t o, input int price, input int maxc,
                                       input bit n, input bit d, input bit c, input bit ack,
                                       input bit cb, input bit rst);
        int val;
        o = '{default: 0};
        val = (n ? 5 : 0) + (d ? 10 : 0);
        if (rst) begin
            m.credit = 0;
            m.phase  = 0;
            m.prev   = 1'b0;
        end else begin
            case (m.phase)
                0: begin
                    if (val > 0) begin
                        if (m.credit + val <= maxc) m.credit += val;
                        else o.rej = 1'b1;
                    end
                    if (c && m.credit > 0) m.phase = 2;
                    else if (m.credit >= price) m.phase = 1;
                end
                1: begin
                    o.rej = (val > 0);
                    if (ack) begin
                        m.credit -= price;
                        m.phase = (m.credit > 0) ? 2 : 0;
                    end
                end
                default: begin
                    o.rej = (val > 0);
                    if (m.credit == 0) m.phase = 0;
                    else if (!cb && !m.prev) begin
                        if (DIME && m.credit >= 10) begin
                            o.chg_d = 1'b1;
                            m.credit -= 10;
                        end else begin
                            o.chg_n = 1'b1;
                            m.credit -= 5;
                        end
                    end
                end
            endcase
            m.prev = o.chg_n | o.chg_d;
        end
        o.credit = m.credit;
        o.open   = (m.phase == 1);
        o.busy   = (m.phase != 0);
    endfunction

    task automatic drive(input bit n, input bit d, input bit c, input bit ack, input bit cb, input bit rst);
        obs_t oa;
        obs_t ob;
        @(negedge clk);
        reset = rst;
        bus_a.N = n; bus_a.D = d; bus_a.cancel = c; bus_a.open_ack = ack; bus_a.chg_busy = cb;
        bus_b.N = n; bus_b.D = d; bus_b.cancel = c; bus_b.open_ack = ack; bus_b.chg_busy = cb;
        model_step(ma, oa, 15, 35, n, d, c, ack, cb, rst);
        model_step(mb, ob, 30, 30, n, d, c, ack, cb, rst);
        qa.push_back(oa);
        qb.push_back(ob);
    endtask

    task automatic compare(input string name, input obs_t e, input logic open, input logic chg_n,
                           input logic chg_d, input logic rej, input logic busy, input logic [5:0] credit);
        logic [5:0] exp_credit;
        exp_credit = 6'(e.credit);
        checks++;
        if ({open, chg_n, chg_d, rej, busy, credit} !== {e.open, e.chg_n, e.chg_d, e.rej, e.busy, exp_credit}) begin
            errors++;
            $display("FAIL %s cycle %0d: got open=%b chg_n=%b chg_d=%b rej=%b busy=%b credit=%0d, expected open=%b chg_n=%b chg_d=%b rej=%b busy=%b credit=%0d",
                     name, cyc, open, chg_n, chg_d, rej, busy, credit,
                     e.open, e.chg_n, e.chg_d, e.rej, e.busy, e.credit);
        end
    endtask

    // Monitor: one expected observation per edge for each configuration.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                compare("cfg15", e, bus_a.open, bus_a.chg_n, bus_a.chg_d, bus_a.coin_reject, bus_a.busy, bus_a.credit);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                compare("cfg30", e, bus_b.open, bus_b.chg_n, bus_b.chg_d, bus_b.coin_reject, bus_b.busy, bus_b.credit);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus_a.N = 1'b0; bus_a.D = 1'b0; bus_a.cancel = 1'b0; bus_a.open_ack = 1'b0; bus_a.chg_busy = 1'b0;
        bus_b.N = 1'b0; bus_b.D = 1'b0; bus_b.cancel = 1'b0; bus_b.open_ack = 1'b0; bus_b.chg_busy = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};
        // Reset state, then the scenarios of interest, then random traffic.
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        // N then D: dispense with no change
        drive(1, 0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        // D, D: dispense with one nickel returned
        drive(0, 1, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);
        // N then cancel; cancel with zero credit
        drive(1, 0, 0, 0, 0, 0); drive(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0); drive(0, 0, 0, 0, 0, 0);
        // N+D together, then a coin during dispense
        drive(1, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        // Overflow rejection in the 30-cent configuration
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0); drive(0, 0, 0, 1, 0, 0);
        // Hopper busy stalls change
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0); drive(0, 1, 0, 0, 1, 0); drive(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        // Reset mid-change with 15 cents held
        drive(1, 0, 0, 0, 0, 0); drive(0, 1, 1, 0, 1, 0); drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
        end
        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
